// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, read-owner codes
// and the saturating starvation-counter increment.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE     = 2'd1,
        DBG      = 2'd2,
        DBG_LOCK = 2'd3
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CORE = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/dmem_arb_resp.sv
// Read-response router: remembers who was granted a read and steers the next-cycle
// m_rdata to that requester, holding each requester's last read data otherwise.
module dmem_arb_resp
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        rd_owner,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              c_rvalid,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic [DATA_W-1:0] d_rdata
);

    logic [1:0]        owner_q, owner_d;
    logic [DATA_W-1:0] c_hold_q, c_hold_d;
    logic [DATA_W-1:0] d_hold_q, d_hold_d;

    always_comb begin
        owner_d  = rd_owner;
        c_rvalid = (owner_q == OWN_CORE);
        d_rvalid = (owner_q == OWN_DBG);
        c_rdata  = c_rvalid ? m_rdata : c_hold_q;
        d_rdata  = d_rvalid ? m_rdata : d_hold_q;
        c_hold_d = c_rdata;
        d_hold_d = d_rdata;
    end

    // Async clear of owner_q also cancels a response still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q  <= OWN_NONE;
            c_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            owner_q  <= owner_d;
            c_hold_q <= c_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter (core vs debug/loader) with lock and starvation guard.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; default is core priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int WAIT_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [2:0]            c_funct3,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic                  c_stall,
    output logic [DATA_W-1:0]     c_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_lock,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DM_ADDRESS-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [2:0]            m_funct3,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam logic [3:0] WaitMaxC = 4'(WAIT_MAX);

    arb_state_e state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       dbg_wins;
    logic       policy_dbg;
    logic [1:0] rd_owner;

`ifdef DMEM_ARB_RR_EN
    logic rr_dbg_q, rr_dbg_d;

    assign policy_dbg = rr_dbg_q;
    // Loser of a conflict wins the next one.
    assign rr_dbg_d   = (c_req && d_req) ? c_gnt : rr_dbg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_dbg_q <= 1'b0;
        end else begin
            rr_dbg_q <= rr_dbg_d;
        end
    end
`else
    assign policy_dbg = 1'b0;
`endif

    always_comb begin
        dbg_wins = (state_q == DBG_LOCK) || (wait_cnt_q == WaitMaxC) || policy_dbg;
        // Grants are forced low while reset is asserted.
        c_gnt    = reset && c_req && !(d_req && dbg_wins);
        d_gnt    = reset && d_req && !(c_req && !dbg_wins);
        c_stall  = c_req && !c_gnt;

        m_read   = (c_gnt && !c_we) || (d_gnt && !d_we);
        m_write  = (c_gnt && c_we) || (d_gnt && d_we);
        m_addr   = '0;
        m_wdata  = '0;
        m_funct3 = '0;
        rd_owner = OWN_NONE;
        if (c_gnt) begin
            m_addr   = c_addr;
            m_wdata  = c_wdata;
            m_funct3 = c_funct3;
            rd_owner = c_we ? OWN_NONE : OWN_CORE;
        end else if (d_gnt) begin
            m_addr   = d_addr;
            m_wdata  = d_wdata;
            m_funct3 = d_funct3;
            rd_owner = d_we ? OWN_NONE : OWN_DBG;
        end

        state_d = state_q;
        if (state_q == DBG_LOCK) begin
            if (!d_req || !d_lock) begin
                state_d = IDLE;
            end
        end else if (d_gnt) begin
            state_d = d_lock ? DBG_LOCK : DBG;
        end else if (c_gnt) begin
            state_d = CORE;
        end

        wait_cnt_d = (d_req && !d_gnt) ? sat_inc4(wait_cnt_q) : 4'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    dmem_arb_resp #(
        .DATA_W(DATA_W)
    ) u_resp (
        .clk     (clk),
        .reset   (reset),
        .rd_owner(rd_owner),
        .m_rdata (m_rdata),
        .c_rvalid(c_rvalid),
        .d_rvalid(d_rvalid),
        .c_rdata (c_rdata),
        .d_rdata (d_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; read responses are tracked in a
// scoreboard queue filled when a read grant is expected and drained on rvalid.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we;
    logic [8:0]  c_addr;
    logic [31:0] c_wdata;
    logic [2:0]  c_funct3;
    logic        c_gnt, c_rvalid, c_stall;
    logic [31:0] c_rdata;
    logic        d_req, d_we, d_lock;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_read, m_write;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_funct3;
    logic [31:0] m_rdata;

    typedef struct {
        logic        dbg;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_c = '0;
    logic [31:0] last_d = '0;

    always #5 clk = ~clk;

    dmem_arbiter u_dut (
        .clk     (clk),
        .reset   (reset),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_funct3(c_funct3),
        .c_gnt   (c_gnt),
        .c_rvalid(c_rvalid),
        .c_stall (c_stall),
        .c_rdata (c_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_lock  (d_lock),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_funct3(d_funct3),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .m_read  (m_read),
        .m_write (m_write),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_funct3(m_funct3),
        .m_rdata (m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance past the rising edge.
    task automatic cyc(input logic eg_c, input logic eg_d, input string tag);
        rsp_t        e;
        logic        crv, drv, push;
        logic [31:0] nd;
        @(negedge clk);
        chk({tag, ".c_gnt"}, c_gnt, eg_c);
        chk({tag, ".d_gnt"}, d_gnt, eg_d);
        chk({tag, ".c_stall"}, c_stall, c_req & ~eg_c);
        chk({tag, ".m_read"}, m_read, (eg_c & ~c_we) | (eg_d & ~d_we));
        chk({tag, ".m_write"}, m_write, (eg_c & c_we) | (eg_d & d_we));
        chk({tag, ".m_addr"}, m_addr, eg_c ? c_addr : (eg_d ? d_addr : 9'd0));
        chk({tag, ".m_wdata"}, m_wdata, eg_c ? c_wdata : (eg_d ? d_wdata : 32'd0));
        chk({tag, ".m_funct3"}, m_funct3, eg_c ? c_funct3 : (eg_d ? d_funct3 : 3'd0));
        crv = 1'b0;
        drv = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            crv = !e.dbg;
            drv = e.dbg;
            if (crv) last_c = e.data;
            if (drv) last_d = e.data;
        end
        chk({tag, ".c_rvalid"}, c_rvalid, crv);
        chk({tag, ".d_rvalid"}, d_rvalid, drv);
        chk({tag, ".c_rdata"}, c_rdata, last_c);
        chk({tag, ".d_rdata"}, d_rdata, last_d);
        push = (eg_c & ~c_we) | (eg_d & ~d_we);
        nd = $urandom;
        if (push) sb.push_back('{dbg: eg_d, data: nd});
        @(posedge clk);
        #1;
        m_rdata = push ? nd : $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h0; c_wdata = '0; c_funct3 = 3'd2;
        d_req = 1'b1; d_we = 1'b0; d_lock = 1'b0; d_addr = 9'h0; d_wdata = '0; d_funct3 = 3'd2;
        m_rdata = 32'hdead_beef;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc(1'b0, 1'b0, "rst_hold");
        c_req = 1'b0; d_req = 1'b0;
        reset = 1'b1;
        cyc(1'b0, 1'b0, "idle");

        // Lone core read, zero-wait, response next cycle.
        c_req = 1'b1; c_addr = 9'h010; c_funct3 = 3'd2;
        cyc(1'b1, 1'b0, "core_rd");
        c_req = 1'b0;
        cyc(1'b0, 1'b0, "core_rsp");

        d_req = 1'b1; d_addr = 9'h020; d_funct3 = 3'd1;
        cyc(1'b0, 1'b1, "dbg_rd");
        d_req = 1'b0;
        cyc(1'b0, 1'b0, "dbg_rsp");

        c_req = 1'b1; c_we = 1'b1; c_addr = 9'h044; c_wdata = 32'h1234_5678; c_funct3 = 3'd0;
        cyc(1'b1, 1'b0, "core_wr");
        c_req = 1'b0; c_we = 1'b0;
        cyc(1'b0, 1'b0, "core_wr_norsp");

        // Continuous conflict.
        c_req = 1'b1; c_addr = 9'h100; c_funct3 = 3'd2;
        d_req = 1'b1; d_addr = 9'h1f0; d_funct3 = 3'd2;
`ifdef DMEM_ARB_RR_EN
        cyc(1'b1, 1'b0, "rr_c0");
        cyc(1'b0, 1'b1, "rr_d0");
        cyc(1'b1, 1'b0, "rr_c1");
        cyc(1'b0, 1'b1, "rr_d1");
`else
        for (int i = 0; i < 8; i++) begin
            c_addr = 9'(9'h100 + 4 * i);
            cyc(1'b1, 1'b0, "prio_core");
        end
        cyc(1'b0, 1'b1, "starve_dbg");
`endif
        c_req = 1'b0; d_req = 1'b0;
        cyc(1'b0, 1'b0, "conflict_flush");

        // Locked debug burst of three writes while core waits.
        d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 9'h080; d_wdata = 32'ha0; d_funct3 = 3'd2;
        cyc(1'b0, 1'b1, "lock_w0");
        c_req = 1'b1; c_addr = 9'h0c0;
        d_addr = 9'h084; d_wdata = 32'ha1;
        cyc(1'b0, 1'b1, "lock_w1");
        d_addr = 9'h088; d_wdata = 32'ha2; d_lock = 1'b0;
        cyc(1'b0, 1'b1, "lock_w2");
        d_req = 1'b0; d_we = 1'b0;
        cyc(1'b1, 1'b0, "lock_core");
        c_req = 1'b0;
        cyc(1'b0, 1'b0, "lock_flush");

        // Lock released by dropping d_req: waiting core granted that cycle.
        d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 9'h090; d_wdata = 32'hb0;
        cyc(1'b0, 1'b1, "lock2_w");
        d_req = 1'b0; d_lock = 1'b0; d_we = 1'b0;
        c_req = 1'b1; c_addr = 9'h0d0;
        cyc(1'b1, 1'b0, "lock2_rel");
        c_req = 1'b0;
        cyc(1'b0, 1'b0, "lock2_flush");

        // Reset in the cycle after a granted read drops the response.
        c_req = 1'b1; c_addr = 9'h0e0;
        cyc(1'b1, 1'b0, "rr_pre");
        c_req = 1'b0;
        reset = 1'b0;
        sb.delete();
        last_c = '0;
        last_d = '0;
        cyc(1'b0, 1'b0, "rst_mid");
        reset = 1'b1;
        cyc(1'b0, 1'b0, "rst_after");
        c_req = 1'b1; c_addr = 9'h004;
        cyc(1'b1, 1'b0, "rst_core_rd");
        c_req = 1'b0;
        cyc(1'b0, 1'b0, "rst_core_rsp");

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, 32, data width.
REQ-002 Parameter DM_ADDRESS, 9, data-memory byte address width.
REQ-003 Parameter WAIT_MAX, 8, starvation limit in cycles for a blocked debug requester; legal range 1..15.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 c_req / c_we  in  1 / 1  core MEM-stage access request / write (0 = read).
REQ-008 c_addr / c_wdata / c_funct3  in  DM_ADDRESS / DATA_W / 3  core address / store data / access size.
REQ-009 c_gnt / c_rvalid / c_stall  out  1 / 1 / 1  core command accepted / core read data valid / freeze core pipeline.
REQ-010 c_rdata  out  DATA_W  core read data.
REQ-011 d_req, d_we, d_lock  in  1 each  debug/loader request, write, hold-ownership.
REQ-012 d_addr / d_wdata / d_funct3  in  DM_ADDRESS / DATA_W / 3  debug address / data / size.
REQ-013 d_gnt / d_rvalid  out  1 / 1  debug command accepted / debug read data valid; d_rdata  out  DATA_W  debug read data.
REQ-014 m_read / m_write  out  1 / 1  memory read / write strobe.
REQ-015 m_addr / m_wdata / m_funct3  out  DM_ADDRESS / DATA_W / 3  memory command fields.
REQ-016 m_rdata  in  DATA_W  memory read data, valid one cycle after m_read.

Function
REQ-017 Requests SHALL be level-held; the requester keeps req and all fields stable until it sees gnt high in the same cycle.
REQ-018 At most one of c_gnt, d_gnt SHALL be high per cycle; the granted requester's fields drive m_* combinationally that cycle; m_read = gnt & ~we, m_write = gnt & we.
REQ-019 With no grant, m_read = m_write = 0 and m_addr/m_wdata/m_funct3 = 0.
REQ-020 FSM states: IDLE, CORE, DBG, DBG_LOCK; state reflects owner of the most recent grant.
REQ-021 Lone requester SHALL be granted in the cycle it requests (zero-wait).
REQ-022 Conflict (c_req & d_req) in IDLE/CORE/DBG: resolved by policy (REQ-031/032); in DBG_LOCK debug always wins.
REQ-023 DBG -> DBG_LOCK when a debug grant occurs with d_lock = 1; DBG_LOCK -> IDLE on first cycle with d_lock = 0 or d_req = 0 (no grant that cycle for debug if d_req = 0).
REQ-024 c_stall = c_req & ~c_gnt, combinational.
REQ-025 Read response: the rvalid of the requester granted a read in cycle N SHALL be high in cycle N+1 only, with rdata = m_rdata; otherwise rdata holds its last value.
REQ-026 Writes produce no rvalid.
REQ-027 Starvation counter wait_cnt (4 bits): increments each cycle d_req is high and not granted; clears on d_gnt or d_req low; saturates at 15.
REQ-028 When wait_cnt = WAIT_MAX, debug SHALL win the next conflict regardless of policy.

Reset
REQ-029 While reset is low: state = IDLE, wait_cnt = 0, all gnt/rvalid/m_read/m_write = 0, c_rdata = d_rdata = 0, c_stall follows REQ-024 with c_gnt = 0.
REQ-030 Reset asserted mid-read SHALL drop the pending rvalid; no response after release.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN defined: conflict winner alternates; the requester that did not win the previous conflict wins the next (first conflict after reset: core).
REQ-032 Macro undefined: fixed priority, core wins every conflict except as forced by REQ-028 and REQ-022.

Structure
REQ-033 Package dmem_arb_pkg SHALL hold the state enum type (arb_state_e) and the owner encoding (OWN_NONE, OWN_CORE, OWN_DBG).
REQ-034 One sub-module, dmem_arb_resp, SHALL register read ownership and route m_rdata/rvalid; the FSM stays in dmem_arbiter.

Verification
REQ-035 c_req read addr 0x010 alone -> c_gnt same cycle, m_read = 1, c_rvalid next cycle with c_rdata = m_rdata.
REQ-036 c_req and d_req held together, macro undefined, WAIT_MAX = 8 -> core granted 8 cycles, debug granted on 9th, c_stall = 1 that cycle.
REQ-037 Macro defined, both requesting continuously -> grants alternate C, D, C, D starting with core.
REQ-038 d_lock = 1 with 3 debug writes while c_req held -> 3 consecutive d_gnt, c_stall = 1 throughout, then core granted.
REQ-039 reset low in cycle after a granted read -> no rvalid, all outputs 0, state IDLE.
